// File: rtl/program_memory_ctrl.sv
// Instruction fetch controller: one outstanding request, WAIT_STATES-deep
// wait phase, then a held response from a read-only instruction array.
module program_memory_ctrl #(
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000,
  parameter int unsigned WAIT_STATES  = 2,
  parameter string       INIT_FILE    = "text.dat",
  // Array image; word i at [i*DATA_WIDTH +: DATA_WIDTH]
  parameter logic [MEMORY_DEPTH*DATA_WIDTH-1:0] INIT_IMAGE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req_Valid_i,
  input  logic [31:0]           Address_i,
  output logic                  Req_Ready_o,
  output logic                  Rsp_Valid_o,
  input  logic                  Rsp_Ready_i,
  output logic [DATA_WIDTH-1:0] Instruction_o,
  output logic [1:0]            Fault_o
);
  localparam int              AW  = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);
  localparam logic [2:0]      WS  = 3'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [DATA_WIDTH-1:0] rom [MEMORY_DEPTH];

  generate
    for (genvar i = 0; i < MEMORY_DEPTH; i++) begin : g_w
      assign rom[i] = INIT_IMAGE[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  state_t                state_q;
  logic [2:0]            cnt_q;
  logic [31:0]           addr_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [1:0]            fault_q;

  logic                  accept;
  logic [31:0]           addr_d;
  logic [31:0]           word_idx;
  logic [1:0]            fault_d;
  logic [DATA_WIDTH-1:0] instr_d;

  // req_ready_q is only ever set while idle, so it alone qualifies acceptance
  assign accept = Req_Valid_i && req_ready_q;

  // Decode from the address as it will be registered, so a zero-wait
  // acceptance reads the array on the same edge it captures the address.
  always_comb begin
    addr_d     = accept ? Address_i : addr_q;
    word_idx   = (addr_d - BASE_ADDRESS) >> 2;
    fault_d[0] = |addr_d[1:0];
    fault_d[1] = (addr_d < BASE_ADDRESS) || (word_idx >= 32'(MEMORY_DEPTH));
    instr_d    = NOP;
    if (fault_d == 2'b00) instr_d = rom[word_idx[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= BASE_ADDRESS;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      instr_q     <= '0;
      fault_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q      <= Address_i;
            cnt_q       <= WS;
            req_ready_q <= 1'b0;
            if (WS == 3'd0) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              instr_q     <= instr_d;
              fault_q     <= fault_d;
            end else begin
              state_q <= S_WAIT;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            instr_q     <= instr_d;
            fault_q     <= fault_d;
          end
        end
        S_RESP: begin
          // Ready is raised on the exit edge, so the earliest next accept is one cycle later
          if (Rsp_Ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign Req_Ready_o   = req_ready_q;
  assign Rsp_Valid_o   = rsp_valid_q;
  assign Instruction_o = instr_q;
  assign Fault_o       = fault_q;

endmodule
